vit_ctrl_213: RTL and testbench
===============================

# vit_ctrl_213

Control sequencer for the (2,1,3) backward-label Viterbi decoder. It accepts received 2-bit symbols over a valid/ready handshake and issues the per-stage ACS enable (`ae`) to the four-state ACS array. It also drives survivor-memory writes, requests path-metric normalisation and hands each completed frame to the traceback unit. It sits between the input symbol buffer and the bACS_213 array / survivor RAM / traceback block.

## Interface
Parameters:
- `W`, 4, path-metric width (matches ACS `W`).
- `L`, 16, trellis stages per frame (tail bits included); 2..255.
- `AW`, 8, survivor-memory address width; L ≤ 2^AW.

Ports:
- `clock` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high; dominates every other input.
- `start` in 1: begin a frame; honoured in IDLE only.
- `sym_valid` in 1: `sym_in` is valid.
- `sym_in` in 2: received hard-decision symbol.
- `sym_ready` out 1: controller can accept a symbol.
- `bm_sym` out 2: registered symbol driving the branch-metric (HD) logic.
- `ae` out 1: ACS enable, one cycle per accepted symbol.
- `pm_init` out 1: one-cycle pulse loading metrics (state 0 = 0, others = all-ones).
- `norm_req` in 1: AND of the MSBs of all four path metrics.
- `norm` out 1: concurrent with `ae`; the metric array subtracts 2^(W-1) on this stage.
- `sm_we` out 1: survivor-memory write strobe.
- `sm_addr` out AW: survivor-memory write address (stage index).
- `tb_start` out 1: one-cycle pulse, frame complete.
- `tb_done` in 1: traceback finished.
- `busy` out 1: high in any state but IDLE.

## Operation
States: IDLE, INIT, RUN, TB_WAIT.
- IDLE: `sym_ready`=0. When `start`=1, go to INIT.
- INIT (1 cycle): `pm_init`=1 and stage counter cleared; then go to RUN.
- RUN: `sym_ready`=1 while `stage_cnt` < L.
  - A handshake (`sym_valid`&`sym_ready`) registers `sym_in` into `bm_sym` and sets `ae` for the next cycle.
  - `stage_cnt` increments on each handshake.
  - Once the L-th symbol is accepted, `sym_ready` drops in the same cycle (combinational on count = L).
  - After the last `ae` and its `sm_we` retire, go to TB_WAIT.
- TB_WAIT: `tb_start` pulses on entry. The controller holds until `tb_done`=1, then returns to IDLE.
  - `tb_done` in any other state is ignored.
- Survivor write: `sm_we` = `ae` delayed one cycle, because ACS `Bx` is registered on the `ae` edge. `sm_addr` = stage index of that `ae`, running 0..L-1.
- Normalisation:
  - `norm_req` sampled high sets a sticky `norm_pend`.
  - The next `ae` cycle asserts `norm`=1 and clears `norm_pend`.
  - At most one `norm` per `ae`. `norm_req` is ignored while `norm_pend` is already set.
- `start` is ignored while `busy`=1.

## Timing
- Reset values:
  - state IDLE.
  - `sym_ready`, `ae`, `pm_init`, `norm`, `sm_we`, `tb_start`, `busy` = 0.
  - `bm_sym`, `sm_addr`, `stage_cnt` = 0.
  - `norm_pend` = 0.
- Latency:
  - handshake at edge n → `ae` high during cycle n+1.
  - `sm_we` high during cycle n+2.
  - `start` → `pm_init` next cycle → `sym_ready` the cycle after.
- Throughput: one symbol per cycle sustained. With `sym_valid` held high, frame length from `start` to `tb_start` = L+4 cycles.
- Back-pressure: gaps in `sym_valid` insert idle cycles with `ae`=0. `bm_sym` holds its value during gaps.
- Simultaneous events:
  - `norm_req` and a handshake in the same cycle → `norm` accompanies the resulting `ae`.
  - `tb_done` in the same cycle as the `tb_start` pulse is accepted, giving a 1-cycle TB_WAIT.
- `reset` mid-frame: all outputs return to reset values next edge. In-flight `ae`/`sm_we` are cancelled and no `tb_start` is issued.
- Counter width: ceil(log2(L+1)), with no wrap inside a frame.

## Structure
- Shared package `params_b213`: `W`, `L`, `AW`, state encoding constants (IDLE=2'd0, INIT=2'd1, RUN=2'd2, TB_WAIT=2'd3), and the normalisation offset constant 2^(W-1).
- One sub-module: `vit_stage_cnt`, a stage counter with terminal-count flag and delayed write-address pipeline.
- The FSM is kept in this top-level module.

## Test plan
- Reset then `start`: `pm_init` high exactly 1 cycle. With L=16 and `sym_valid` held high, there are 16 `ae` pulses, `sm_addr` runs 0..15 on `sm_we`, and `tb_start` pulses at cycle 20 after `start`.
- Random `sym_valid` gaps (50%): the `ae` count is still 16, and each `bm_sym` equals the accepted `sym_in` sequence.
- `norm_req` held high 3 cycles mid-frame: exactly one `norm`, on the next `ae`. Pulsing `norm_req` again later produces a second `norm`.
- `start` asserted during RUN and TB_WAIT: ignored, no extra `pm_init`. Delaying `tb_done` 10 cycles keeps `busy`=1 and `sym_ready`=0 throughout.
- `reset` on the 7th handshake cycle: next cycle all outputs are 0 and the state is IDLE. A fresh `start` then completes a full 16-stage frame.
- `sym_valid` held after the 16th symbol: `sym_ready` is 0 from that cycle, and no 17th `ae` or `sm_we` occurs.

Source files
------------

// File: rtl/vit_ctrl_213_pkg.sv
// Shared constants and state type for the (2,1,3) Viterbi decoder slice.
package params_b213;

  localparam int unsigned W  = 4;   // path-metric width
  localparam int unsigned L  = 16;  // trellis stages per frame, tail included
  localparam int unsigned AW = 8;   // survivor-memory address width

  // Amount the ACS array subtracts from every metric on a norm stage.
  localparam logic [W-1:0] NORM_OFS = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INIT    = 2'd1,
    RUN     = 2'd2,
    TB_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/vit_ctrl_213_stage_cnt.sv
// Stage counter with terminal-count flag and a two-step address pipeline
// that follows a symbol from handshake through ae to its survivor write.
module vit_stage_cnt
  import params_b213::*;
#(
  parameter int unsigned L  = params_b213::L,
  parameter int unsigned AW = params_b213::AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic          ae_i,
  output logic          tc_o,
  output logic [AW-1:0] addr_o
);

  localparam int unsigned CW = $clog2(L + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ae_addr_q, ae_addr_d;
  logic [AW-1:0] we_addr_q, we_addr_d;

  assign tc_o   = (cnt_q == CW'(L));
  assign addr_o = we_addr_q;

  // Next-state: count handshakes, capture stage index on handshake, move it on ae.
  always_comb begin
    cnt_d     = cnt_q;
    ae_addr_d = ae_addr_q;
    we_addr_d = we_addr_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (inc_i) begin
      ae_addr_d = AW'(cnt_q);
    end
    if (ae_i) begin
      we_addr_d = ae_addr_q;
    end
  end

  // Register update with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      ae_addr_q <= '0;
      we_addr_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      ae_addr_q <= ae_addr_d;
      we_addr_q <= we_addr_d;
    end
  end

endmodule

// File: rtl/vit_ctrl_213.sv
// Control sequencer for the (2,1,3) backward-label Viterbi decoder: symbol
// intake, ACS enable, survivor writes, normalisation and traceback hand-off.
module vit_ctrl_213
  import params_b213::*;
#(
  parameter int unsigned W  = params_b213::W,
  parameter int unsigned L  = params_b213::L,
  parameter int unsigned AW = params_b213::AW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          sym_valid,
  input  logic [1:0]    sym_in,
  output logic          sym_ready,
  output logic [1:0]    bm_sym,
  output logic          ae,
  output logic          pm_init,
  input  logic          norm_req,
  output logic          norm,
  output logic          sm_we,
  output logic [AW-1:0] sm_addr,
  output logic          tb_start,
  input  logic          tb_done,
  output logic          busy
);

  if (W < 2 || L < 2 || L > 255 || L > (1 << AW)) begin : g_bad_param
    $error("vit_ctrl_213: illegal W/L/AW combination");
  end

  state_e     state_q;
  logic [1:0] bm_sym_q;
  logic       ae_q, pm_init_q, norm_q, norm_pend_q, sm_we_q, tb_start_q;
  logic       tc, hs;

  assign sym_ready = (state_q == RUN) && !tc;
  assign hs        = sym_ready && sym_valid;

  assign bm_sym   = bm_sym_q;
  assign ae       = ae_q;
  assign pm_init  = pm_init_q;
  assign norm     = norm_q;
  assign sm_we    = sm_we_q;
  assign tb_start = tb_start_q;
  assign busy     = (state_q != IDLE);

  vit_stage_cnt #(
    .L  (L),
    .AW (AW)
  ) u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (state_q == INIT),
    .inc_i  (hs),
    .ae_i   (ae_q),
    .tc_o   (tc),
    .addr_o (sm_addr)
  );

  // Frame FSM with registered strobes; ae/sm_we form a two-stage pipeline off the handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      bm_sym_q    <= '0;
      ae_q        <= 1'b0;
      pm_init_q   <= 1'b0;
      norm_q      <= 1'b0;
      norm_pend_q <= 1'b0;
      sm_we_q     <= 1'b0;
      tb_start_q  <= 1'b0;
    end else begin
      pm_init_q  <= 1'b0;
      tb_start_q <= 1'b0;
      ae_q       <= hs;
      sm_we_q    <= ae_q;

      // A request arriving with a handshake rides on that very ae.
      if (hs) begin
        bm_sym_q    <= sym_in;
        norm_q      <= norm_pend_q | norm_req;
        norm_pend_q <= 1'b0;
      end else begin
        norm_q      <= 1'b0;
        norm_pend_q <= norm_pend_q | norm_req;
      end

      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= INIT;
            pm_init_q <= 1'b1;
          end
        end
        INIT: begin
          state_q     <= RUN;
          // Metrics are being reloaded, so any earlier request is stale.
          norm_pend_q <= 1'b0;
        end
        RUN: begin
          // All symbols taken, last ae gone, last survivor write in flight now.
          if (tc && !ae_q && sm_we_q) begin
            state_q    <= TB_WAIT;
            tb_start_q <= 1'b1;
          end
        end
        TB_WAIT: begin
          if (tb_done) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vit_ctrl_213.sv
// Self-checking bench for vit_ctrl_213: randomized symbol traffic against an
// event-schedule reference model (expected strobes booked per absolute cycle).
module tb_vit_ctrl_213;

  localparam int LEN = 16;
  localparam int NC  = 4096;

  logic       clock, reset, start, sym_valid, norm_req, tb_done;
  logic [1:0] sym_in;
  logic       sym_ready, ae, pm_init, norm, sm_we, tb_start, busy;
  logic [1:0] bm_sym;
  logic [7:0] sm_addr;

  vit_ctrl_213 #(.W(4), .L(LEN), .AW(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .sym_valid (sym_valid),
    .sym_in    (sym_in),
    .sym_ready (sym_ready),
    .bm_sym    (bm_sym),
    .ae        (ae),
    .pm_init   (pm_init),
    .norm_req  (norm_req),
    .norm      (norm),
    .sm_we     (sm_we),
    .sm_addr   (sm_addr),
    .tb_start  (tb_start),
    .tb_done   (tb_done),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: expected events per cycle plus frame bookkeeping.
  bit       exp_ae [NC];
  bit       exp_norm [NC];
  bit       exp_we [NC];
  bit       exp_pmi [NC];
  bit       rst_at [NC];
  bit [1:0] exp_sym [NC];
  bit [7:0] exp_addr [NC];

  int       cyc = 0;
  bit       busy_m = 0;
  bit       pend_m = 0;
  int       ready_at = 0;
  int       nacc = 0;
  int       tbs_cyc = -1;
  int       start_cyc = 0;
  int       tbs_rel = 0;
  bit [1:0] bm_hold = 0;
  bit [7:0] addr_hold = 0;
  int       tbd_delay = 0;
  bit       tbd_noise = 0;
  int       f_ae, f_we, f_norm, f_pmi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_ready();
    return busy_m && (cyc >= ready_at) && (nacc < LEN);
  endfunction

  // One clock: check ready, advance model across the edge, check registered outputs.
  task automatic tick();
    bit rdy;
    if (tbs_cyc >= 0) tb_done = (cyc >= tbs_cyc + tbd_delay);
    else              tb_done = tbd_noise ? 1'($urandom_range(0, 1)) : 1'b0;
    rdy = exp_ready();
    chk("sym_ready", sym_ready, rdy);

    if (reset) begin
      for (int k = 1; k <= 3; k++) begin
        exp_ae[cyc+k] = 0; exp_we[cyc+k] = 0; exp_pmi[cyc+k] = 0; exp_norm[cyc+k] = 0;
      end
      rst_at[cyc+1] = 1;
      busy_m = 0; pend_m = 0; tbs_cyc = -1; nacc = 0;
    end else if (!busy_m) begin
      if (start) begin
        busy_m = 1; exp_pmi[cyc+1] = 1; ready_at = cyc + 2;
        nacc = 0; start_cyc = cyc; tbs_cyc = -1;
      end
      pend_m = pend_m | norm_req;
    end else begin
      if (rdy && sym_valid) begin
        exp_ae[cyc+1]   = 1;
        exp_sym[cyc+1]  = sym_in;
        exp_norm[cyc+1] = pend_m | norm_req;
        pend_m = 0;
        exp_we[cyc+2]   = 1;
        exp_addr[cyc+2] = 8'(nacc);
        nacc++;
        if (nacc == LEN) begin
          tbs_cyc = cyc + 3;
          tbs_rel = tbs_cyc - start_cyc;
        end
      end else if (cyc == ready_at - 1) begin
        pend_m = 0;
      end else begin
        pend_m = pend_m | norm_req;
      end
      if (tbs_cyc >= 0 && cyc >= tbs_cyc && tb_done) begin
        busy_m = 0; tbs_cyc = -1;
      end
    end

    @(posedge clock);
    cyc++;
    #1;
    if (cyc >= NC - 4) begin
      $display("FAIL cycle_budget got=%0d exp<%0d", cyc, NC - 4);
      $fatal(1, "cycle budget exhausted");
    end
    if (rst_at[cyc]) begin bm_hold = 0; addr_hold = 0; end
    if (exp_ae[cyc]) bm_hold = exp_sym[cyc];
    if (exp_we[cyc]) addr_hold = exp_addr[cyc];
    chk("ae",       ae,       exp_ae[cyc]);
    chk("norm",     norm,     exp_norm[cyc]);
    chk("sm_we",    sm_we,    exp_we[cyc]);
    chk("sm_addr",  sm_addr,  addr_hold);
    chk("bm_sym",   bm_sym,   bm_hold);
    chk("pm_init",  pm_init,  exp_pmi[cyc]);
    chk("tb_start", tb_start, (cyc == tbs_cyc));
    chk("busy",     busy,     busy_m);
    if (ae === 1'b1)      f_ae++;
    if (sm_we === 1'b1)   f_we++;
    if (norm === 1'b1)    f_norm++;
    if (pm_init === 1'b1) f_pmi++;
  endtask

  // One frame: start, traffic until the model says it is over, frame-level totals.
  task automatic frame(input int vpct, input int tdly, input bit nmode,
                       input bit snoise, input bit rst7, input bit dnoise);
    int  rel;
    bit  aborted;
    aborted = 0;
    tbd_delay = tdly; tbd_noise = dnoise;
    f_ae = 0; f_we = 0; f_norm = 0; f_pmi = 0; tbs_rel = 0;
    start = 1; sym_valid = 0; norm_req = 0;
    tick();
    start = 0;
    for (int i = 0; i < 300 && busy_m; i++) begin
      rel       = cyc - start_cyc;
      sym_in    = 2'($urandom);
      sym_valid = ($urandom_range(0, 99) < vpct);
      norm_req  = 0;
      if (nmode) begin
        if (rel >= 8 && rel <= 10) begin norm_req = 1; sym_valid = 0; end
        if (rel == 14) norm_req = 1;
      end
      start = snoise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rst7 && exp_ready() && nacc == 6) begin
        reset = 1; sym_valid = 1; aborted = 1;
      end
      tick();
      reset = 0;
      if (aborted) break;
    end
    start = 0; sym_valid = 0; norm_req = 0; tbd_noise = 0;
    if (!aborted) begin
      chk("frame_timeout", busy, 1'b0);
      chk("ae_count", f_ae, LEN);
      chk("we_count", f_we, LEN);
      chk("pm_init_count", f_pmi, 1);
      if (vpct == 100 && !nmode) chk("tb_start_latency", tbs_rel, LEN + 4);
      if (nmode) chk("norm_count", f_norm, 2);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sym_valid = 1'($urandom_range(0, 1));
      sym_in    = 2'($urandom);
      tick();
    end
    sym_valid = 0;
  endtask

  initial begin
    reset = 1; start = 0; sym_valid = 0; sym_in = 0; norm_req = 0; tb_done = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_sym_ready", sym_ready, 1'b0);
    chk("rst_ae",        ae,        1'b0);
    chk("rst_pm_init",   pm_init,   1'b0);
    chk("rst_norm",      norm,      1'b0);
    chk("rst_sm_we",     sm_we,     1'b0);
    chk("rst_tb_start",  tb_start,  1'b0);
    chk("rst_busy",      busy,      1'b0);
    chk("rst_bm_sym",    bm_sym,    2'd0);
    chk("rst_sm_addr",   sm_addr,   8'd0);
    reset = 0;
    idle(3);

    // Streaming frame, traceback done on the tb_start cycle; valid held past the 16th symbol.
    frame(100, 0, 0, 0, 0, 0);
    idle(2);
    // Random 50% gaps, tb_done noise before the hand-off.
    frame(50, 3, 0, 0, 0, 1);
    idle(2);
    // Normalisation: 3-cycle request in a gap, then a single pulse later.
    frame(100, 2, 1, 0, 0, 0);
    idle(2);
    // start hammered while busy, traceback delayed 10 cycles.
    frame(100, 10, 0, 1, 0, 0);
    idle(2);
    // Reset on the 7th handshake, then a fresh complete frame.
    frame(100, 1, 0, 0, 1, 0);
    idle(3);
    frame(60, 4, 0, 0, 0, 0);
    idle(2);
    frame(30, 0, 0, 1, 0, 1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
